// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// serializer state encoding, register offsets (addr[3:2]) and STATUS bit positions.
// No ports; imported by uart_tx_fifo and its sub-modules.
package uart_tx_fifo_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;

   // Register offsets as decoded from addr[3:2]
   localparam logic [1:0] TXDATA_OFF = 2'd0;
   localparam logic [1:0] STATUS_OFF = 2'd1;

   // STATUS register bit positions
   localparam int STAT_FULL_BIT   = 0;
   localparam int STAT_EMPTY_BIT  = 1;
   localparam int STAT_BUSY_BIT   = 2;
   localparam int STAT_PARITY_BIT = 3;

endpackage

// File: rtl/uart_tx_fifo_mem.sv
// Circular synchronous FIFO holding bytes waiting for the serializer.
// Latency: a push is visible at o_rdata the cycle after; o_rdata is the combinational head.
// Backpressure: caller must not push when full (unless popping) nor pop when empty.
// Ports: clock, reset (async, active-high), i_push/i_wdata, i_pop, o_rdata (head),
//        o_full, o_empty, o_count (entries held).
module uart_tx_fifo_mem #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   // One extra pointer bit: equal low bits with differing MSB means full.
   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;

   always_ff @(posedge clock) begin
      if (i_push) begin
         r_mem[r_wptr[AW-1:0]] <= i_wdata;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (i_push) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
         if (i_pop)  r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
      end
   end

   // When full, a simultaneous push writes the slot being popped; the pop
   // reads the old value combinationally before the write lands.
   assign o_rdata = r_mem[r_rptr[AW-1:0]];
   assign o_empty = (r_wptr == r_rptr);
   assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign o_count = r_wptr - r_rptr;

endmodule

// File: rtl/uart_tx_fifo.sv
// Memory-mapped UART transmitter: bus writes to TXDATA queue bytes, serialized as 8N1 on uart_txd.
// Latency: uart_ready one cycle after a request is sampled; first start bit 2 cycles after the push.
// Backpressure: a TXDATA write to a full FIFO holds uart_ready low until the serializer pops.
// Ports: clock, reset (async, active-high); uart_valid/instr/addr/wdata/wstrb request in;
//        uart_rdata/uart_ready response out; uart_txd serial out (idle high).
// Build option: define UART_TX_PARITY_EN to add an even-parity bit (8E1) and set STATUS bit 3.
module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int FIFO_DEPTH   = 16,
   parameter int CLKS_PER_BIT = 868
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        uart_valid,
   input  logic        uart_instr,
   input  logic [31:0] uart_addr,
   input  logic [31:0] uart_wdata,
   input  logic [3:0]  uart_wstrb,
   output logic [31:0] uart_rdata,
   output logic        uart_ready,
   output logic        uart_txd
);

   localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam int            CW        = $clog2(FIFO_DEPTH) + 1;

`ifdef UART_TX_PARITY_EN
   localparam logic PARITY_CAP = 1'b1;
`else
   localparam logic PARITY_CAP = 1'b0;
`endif

   tx_state_t     r_state, w_state_nxt;
   logic [BW-1:0] r_baud, w_baud_nxt;
   logic [2:0]    r_idx, w_idx_nxt;
   logic [7:0]    r_sh, w_sh_nxt;
   logic          r_txd, w_txd_nxt;
   logic          r_ready;
   logic [31:0]   r_rdata;

   logic          w_push, w_pop, w_full, w_empty, w_bit_done;
   logic [7:0]    w_head;
   logic [CW-1:0] w_count;
   logic          w_req, w_is_rd, w_tx_wr, w_ack;
   logic [31:0]   w_status, w_rd_val;
   logic          w_unused;

   uart_tx_fifo_mem #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .i_push  (w_push),
      .i_wdata (uart_wdata[7:0]),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // ---------------- bus decode and handshake ----------------
   always_comb begin
      w_status                  = '0;
      w_status[STAT_FULL_BIT]   = w_full;
      w_status[STAT_EMPTY_BIT]  = w_empty;
      w_status[STAT_BUSY_BIT]   = (r_state != ST_IDLE);
      w_status[STAT_PARITY_BIT] = PARITY_CAP;

      // A request is never taken in the cycle ready is high.
      w_req   = uart_valid & ~r_ready;
      w_is_rd = (uart_wstrb == 4'b0000);
      w_tx_wr = w_req & ~uart_instr & ~w_is_rd & uart_wstrb[0] &
                (uart_addr[3:2] == TXDATA_OFF);
      // A full FIFO can still accept when the serializer pops this cycle.
      w_push  = w_tx_wr & (~w_full | w_pop);
      w_ack   = w_req & (~w_tx_wr | w_push);

      w_rd_val = '0;
      if (~uart_instr && w_is_rd && (uart_addr[3:2] == STATUS_OFF)) begin
         w_rd_val = w_status;
      end
   end

   // ---------------- serializer next-state ----------------
   assign w_bit_done = (r_baud == BAUD_LAST);

   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = w_bit_done ? '0 : r_baud + BW'(1);
      w_idx_nxt   = r_idx;
      w_sh_nxt    = r_sh;
      w_pop       = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_baud_nxt = '0;
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_sh_nxt    = w_head;
               w_state_nxt = ST_START;
            end
         end
         ST_START: begin
            if (w_bit_done) begin
               w_state_nxt = ST_DATA;
               w_idx_nxt   = 3'd0;
            end
         end
         ST_DATA: begin
            if (w_bit_done) begin
               if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  w_state_nxt = ST_PARITY;
`else
                  w_state_nxt = ST_STOP;
`endif
               end else begin
                  w_idx_nxt = r_idx + 3'd1;
               end
            end
         end
         ST_PARITY: begin
            if (w_bit_done) w_state_nxt = ST_STOP;
         end
         ST_STOP: begin
            if (w_bit_done) begin
               // Chain straight into the next frame when more data is queued.
               if (!w_empty) begin
                  w_pop       = 1'b1;
                  w_sh_nxt    = w_head;
                  w_state_nxt = ST_START;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_baud_nxt  = '0;
         end
      endcase

      // txd is registered from the next state so it lines up with r_state.
      case (w_state_nxt)
         ST_START:  w_txd_nxt = 1'b0;
         ST_DATA:   w_txd_nxt = w_sh_nxt[w_idx_nxt];
         ST_PARITY: w_txd_nxt = ^w_sh_nxt;
         default:   w_txd_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_baud  <= '0;
         r_idx   <= '0;
         r_sh    <= '0;
         r_txd   <= 1'b1;
         r_ready <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_baud  <= w_baud_nxt;
         r_idx   <= w_idx_nxt;
         r_sh    <= w_sh_nxt;
         r_txd   <= w_txd_nxt;
         r_ready <= w_ack;
         r_rdata <= w_ack ? w_rd_val : '0;
      end
   end

   assign uart_ready = r_ready;
   assign uart_rdata = r_rdata;
   assign uart_txd   = r_txd;

   assign w_unused = &{1'b0, uart_addr[31:4], uart_addr[1:0], uart_wdata[31:8], w_count};

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int          NBITS = 11;
   localparam logic [31:0] PBIT  = 32'h8;
`else
   localparam int          NBITS = 10;
   localparam logic [31:0] PBIT  = 32'h0;
`endif
   localparam int FRAME = NBITS * CPB;
   localparam logic [31:0] ST_IDLE_EMPTY = 32'h2 | PBIT;
   localparam logic [31:0] ST_BUSY_FULL  = 32'h5 | PBIT;

   logic        clock = 1'b0;
   logic        reset;
   logic        uart_valid = 1'b0;
   logic        uart_instr = 1'b0;
   logic [31:0] uart_addr  = '0;
   logic [31:0] uart_wdata = '0;
   logic [3:0]  uart_wstrb = '0;
   logic [31:0] uart_rdata;
   logic        uart_ready;
   logic        uart_txd;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
      .clock      (clock),
      .reset      (reset),
      .uart_valid (uart_valid),
      .uart_instr (uart_instr),
      .uart_addr  (uart_addr),
      .uart_wdata (uart_wdata),
      .uart_wstrb (uart_wstrb),
      .uart_rdata (uart_rdata),
      .uart_ready (uart_ready),
      .uart_txd   (uart_txd)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Expected line level for bit slot j of a frame carrying d.
   function automatic logic frame_bit(input logic [7:0] d, input int j);
      if (j == 0) return 1'b0;
      if (j <= 8) return d[j-1];
      if (NBITS == 11 && j == 9) return ^d;
      return 1'b1;
   endfunction

   // Serial receiver model: samples mid-bit, queues received bytes.
   logic [7:0] rxq[$];
   bit         rx_busy = 0;
   int         rx_cnt  = 0;
   logic [7:0] rx_sh   = '0;
   always @(negedge clock) begin
      if (reset) begin
         rx_busy = 0;
         rxq.delete();
      end else if (!rx_busy) begin
         if (uart_txd == 1'b0) begin
            rx_busy = 1;
            rx_cnt  = 0;
         end
      end else begin
         rx_cnt++;
         if ((rx_cnt % CPB) == CPB/2 && rx_cnt/CPB >= 1 && rx_cnt/CPB <= 8)
            rx_sh[rx_cnt/CPB - 1] = uart_txd;
         if (rx_cnt == FRAME - 1) begin
            rx_busy = 0;
            rxq.push_back(rx_sh);
         end
      end
   end

   // One bus transaction; returns response data, cycles to ready, and whether ready came.
   task automatic bus_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic ins, output logic [31:0] rd, output int lat, output bit ok);
      int t0;
      @(negedge clock);
      uart_valid = 1'b1; uart_addr = a; uart_wdata = d; uart_wstrb = s; uart_instr = ins;
      ok = 0; rd = '0; t0 = cyc; lat = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (uart_ready) begin
            ok = 1; rd = uart_rdata; lat = cyc - t0;
            break;
         end
      end
      uart_valid = 1'b0; uart_instr = 1'b0; uart_wstrb = '0;
   endtask

   task automatic test_reset();
      logic [31:0] rd; int lat; bit ok;
      reset = 1'b0;
      #1 reset = 1'b1;
      #3;
      n_checks++; if (uart_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", uart_ready); end
      n_checks++; if (uart_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", uart_rdata); end
      n_checks++; if (uart_txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b want 1", uart_txd); end
      repeat (2) @(negedge clock);
      reset = 1'b0;
      bus_xfer(32'h4, 32'h0, 4'h0, 1'b0, rd, lat, ok);
      n_checks++; if (!ok || rd !== ST_IDLE_EMPTY) begin n_fail++; $display("FAIL reset_status: got %h ok=%0d want %h", rd, ok, ST_IDLE_EMPTY); end
   endtask

   task automatic test_regmap();
      logic [31:0] rd; int lat; bit ok; int lows;
      bus_xfer(32'h8, 32'h0, 4'h0, 1'b0, rd, lat, ok);
      n_checks++; if (!ok || rd !== 32'h0 || lat != 1) begin n_fail++; $display("FAIL read_addr8: got %h lat=%0d want 0 lat=1", rd, lat); end
      @(negedge clock);
      n_checks++; if (uart_ready !== 1'b0 || uart_rdata !== 32'h0) begin n_fail++; $display("FAIL ready_pulse: ready=%b rdata=%h want 0/0", uart_ready, uart_rdata); end
      bus_xfer(32'h0, 32'h0, 4'h0, 1'b0, rd, lat, ok);
      n_checks++; if (!ok || rd !== 32'h0) begin n_fail++; $display("FAIL read_txdata: got %h want 0", rd); end
      bus_xfer(32'hC, 32'h0, 4'h0, 1'b0, rd, lat, ok);
      n_checks++; if (!ok || rd !== 32'h0) begin n_fail++; $display("FAIL read_addrC: got %h want 0", rd); end
      bus_xfer(32'h4, 32'hFF, 4'hF, 1'b0, rd, lat, ok);
      n_checks++; if (!ok || lat != 1) begin n_fail++; $display("FAIL write_status_ack: ok=%0d lat=%0d want 1/1", ok, lat); end
      bus_xfer(32'h0, 32'h99, 4'h1, 1'b1, rd, lat, ok);
      n_checks++; if (!ok || rd !== 32'h0 || lat != 1) begin n_fail++; $display("FAIL instr_fetch: got %h lat=%0d want 0 lat=1", rd, lat); end
      bus_xfer(32'h0, 32'h77, 4'h2, 1'b0, rd, lat, ok);
      n_checks++; if (!ok || lat != 1) begin n_fail++; $display("FAIL txdata_nostrb_ack: ok=%0d lat=%0d want 1/1", ok, lat); end
      bus_xfer(32'h4, 32'h0, 4'h0, 1'b0, rd, lat, ok);
      n_checks++; if (rd !== ST_IDLE_EMPTY) begin n_fail++; $display("FAIL no_push_status: got %h want %h", rd, ST_IDLE_EMPTY); end
      lows = 0;
      repeat (3 * CPB) begin @(negedge clock); if (uart_txd !== 1'b1) lows++; end
      n_checks++; if (lows != 0 || rxq.size() != 0) begin n_fail++; $display("FAIL no_push_line: low samples %0d frames %0d want 0/0", lows, rxq.size()); end
   endtask

   task automatic test_frame(input logic [7:0] d);
      logic [31:0] rd; int lat; bit ok; logic e;
      rxq.delete();
      bus_xfer(32'h0, {24'h0, d}, 4'h1, 1'b0, rd, lat, ok);
      n_checks++; if (!ok || lat != 1) begin n_fail++; $display("FAIL frame_%h_ready: ok=%0d lat=%0d want 1/1", d, ok, lat); end
      n_checks++; if (uart_txd !== 1'b1) begin n_fail++; $display("FAIL frame_%h_pre: txd=%b want 1", d, uart_txd); end
      for (int k = 1; k <= FRAME; k++) begin
         @(negedge clock);
         e = frame_bit(d, (k - 1) / CPB);
         n_checks++; if (uart_txd !== e) begin n_fail++; $display("FAIL frame_%h_sample%0d: txd=%b want %b", d, k, uart_txd, e); end
      end
      @(negedge clock);
      n_checks++; if (uart_txd !== 1'b1) begin n_fail++; $display("FAIL frame_%h_post: txd=%b want 1", d, uart_txd); end
      n_checks++; if (rxq.size() != 1 || rxq[0] !== d) begin n_fail++; $display("FAIL frame_%h_rx: frames=%0d want 1 byte %h", d, rxq.size(), d); end
      bus_xfer(32'h4, 32'h0, 4'h0, 1'b0, rd, lat, ok);
      n_checks++; if (rd !== ST_IDLE_EMPTY) begin n_fail++; $display("FAIL frame_%h_status: got %h want %h", d, rd, ST_IDLE_EMPTY); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd, rd2; int lat, lat2; bit ok, ok2;
      rxq.delete();
      bus_xfer(32'h0, 32'h41, 4'h1, 1'b0, rd, lat, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_first_ack: ok=%0d want 1", ok); end
      fork
         bus_xfer(32'h0, 32'h42, 4'h1, 1'b0, rd2, lat2, ok2);
         for (int k = 1; k <= 2 * FRAME; k++) begin
            logic [7:0] dd; logic e;
            @(negedge clock);
            dd = ((k - 1) / FRAME == 0) ? 8'h41 : 8'h42;
            e  = frame_bit(dd, ((k - 1) % FRAME) / CPB);
            n_checks++; if (uart_txd !== e) begin n_fail++; $display("FAIL b2b_sample%0d: txd=%b want %b", k, uart_txd, e); end
         end
      join
      n_checks++; if (!ok2 || lat2 != 1) begin n_fail++; $display("FAIL b2b_second_ack: ok=%0d lat=%0d want 1/1", ok2, lat2); end
      @(negedge clock);
      n_checks++; if (uart_txd !== 1'b1) begin n_fail++; $display("FAIL b2b_post: txd=%b want 1", uart_txd); end
      n_checks++; if (rxq.size() != 2 || rxq[0] !== 8'h41 || rxq[1] !== 8'h42) begin n_fail++; $display("FAIL b2b_rx: frames=%0d want 41,42", rxq.size()); end
   endtask

   task automatic test_fifo_full();
      logic [31:0] rd; int lat; bit ok; int t1;
      rxq.delete();
      // The first byte moves straight into the shift register, so bytes 2..5 fill the FIFO.
      bus_xfer(32'h0, 32'h11, 4'h1, 1'b0, rd, lat, ok);
      t1 = cyc;
      for (int i = 2; i <= 5; i++) begin
         bus_xfer(32'h0, 32'h10 + i, 4'h1, 1'b0, rd, lat, ok);
         n_checks++; if (!ok || lat != 1) begin n_fail++; $display("FAIL full_write%0d: ok=%0d lat=%0d want 1/1", i, ok, lat); end
      end
      bus_xfer(32'h4, 32'h0, 4'h0, 1'b0, rd, lat, ok);
      n_checks++; if (rd !== ST_BUSY_FULL) begin n_fail++; $display("FAIL full_status: got %h want %h", rd, ST_BUSY_FULL); end
      bus_xfer(32'h0, 32'h16, 4'h1, 1'b0, rd, lat, ok);
      n_checks++; if (!ok || cyc != t1 + FRAME + 1) begin n_fail++; $display("FAIL full_stall: ready at cycle %0d want %0d", cyc, t1 + FRAME + 1); end
      bus_xfer(32'h4, 32'h0, 4'h0, 1'b0, rd, lat, ok);
      n_checks++; if (rd !== ST_BUSY_FULL) begin n_fail++; $display("FAIL full_keep_count: got %h want %h", rd, ST_BUSY_FULL); end
      for (int i = 0; i < 7 * FRAME && rxq.size() < 6; i++) @(negedge clock);
      n_checks++; if (rxq.size() != 6) begin n_fail++; $display("FAIL full_drain: frames=%0d want 6", rxq.size()); end
      for (int i = 0; i < 6 && i < rxq.size(); i++) begin
         n_checks++; if (rxq[i] !== 8'(8'h11 + i)) begin n_fail++; $display("FAIL full_rx%0d: got %h want %h", i, rxq[i], 8'(8'h11 + i)); end
      end
      bus_xfer(32'h4, 32'h0, 4'h0, 1'b0, rd, lat, ok);
      n_checks++; if (rd !== ST_IDLE_EMPTY) begin n_fail++; $display("FAIL full_end_status: got %h want %h", rd, ST_IDLE_EMPTY); end
   endtask

   task automatic test_reset_midframe();
      logic [31:0] rd; int lat; bit ok; int lows;
      bus_xfer(32'h0, 32'hA5, 4'h1, 1'b0, rd, lat, ok);
      repeat (3 * CPB) @(negedge clock);
      // Slot 2 carries data bit 1 of 0xA5, which is 0.
      n_checks++; if (uart_txd !== 1'b0) begin n_fail++; $display("FAIL midframe_pre: txd=%b want 0", uart_txd); end
      reset = 1'b1;
      #1;
      n_checks++; if (uart_txd !== 1'b1) begin n_fail++; $display("FAIL midframe_abort: txd=%b want 1", uart_txd); end
      repeat (2) @(negedge clock);
      reset = 1'b0;
      bus_xfer(32'h4, 32'h0, 4'h0, 1'b0, rd, lat, ok);
      n_checks++; if (rd !== ST_IDLE_EMPTY) begin n_fail++; $display("FAIL midframe_status: got %h want %h", rd, ST_IDLE_EMPTY); end
      lows = 0;
      repeat (FRAME + 8) begin @(negedge clock); if (uart_txd !== 1'b1) lows++; end
      n_checks++; if (lows != 0 || rxq.size() != 0) begin n_fail++; $display("FAIL midframe_quiet: low samples %0d frames %0d want 0/0", lows, rxq.size()); end
   endtask

   initial begin
      test_reset();
      test_regmap();
      test_frame(8'h55);
`ifdef UART_TX_PARITY_EN
      test_frame(8'h07);
`endif
      test_back_to_back();
      test_fifo_full();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
